dplca_txop_claim_tracker: RTL and testbench

- Producer side of the DPLCA node-ID assignment state machine.
- Observes PLCA TXOPs on the mixing segment and maintains the 256-entry TXOP claim table.
- Ages the table every AGING_CYCLES beacon cycles and emits update/new-age strobes.
- Drives txop_claim_table_unpacked, dplca_txop_table_upd, dplca_new_age, dplca_txop_id and dplca_txop_node_count; consumes dplca_aging from that machine.

---
 rtl/dplca_txop_claim_tracker.sv | 143 ++++++++++++++
 tb/tb_dplca_txop_claim_tracker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dplca_txop_claim_tracker.sv
// dplca_txop_claim_tracker: DPLCA TXOP claim table with beacon-driven aging and update strobes.
// Optional DPLCA_CLAIM_STATS_EN adds a registered free_count output.
module dplca_txop_claim_tracker #(
    parameter int AGING_CYCLES = 16,
    parameter int CLAIM_W = 2
) (
    input  logic                 clk,
    input  logic                 plca_reset_n,
    input  logic                 dplca_aging,
    input  logic                 plca_status,
    input  logic [1:0]           rx_cmd,
    input  logic                 plca_tx_beacon,
    input  logic [7:0]           plca_node_count,
    input  logic [7:0]           curID,
    input  logic                 txop_start,
    input  logic                 txop_end,
    input  logic                 CRS,
    input  logic                 local_tx,
    output logic [256*CLAIM_W-1:0] txop_claim_table_unpacked,
    output logic                 dplca_txop_table_upd,
    output logic                 dplca_new_age,
    output logic [7:0]           dplca_txop_id,
    output logic [7:0]           dplca_txop_node_count
`ifdef DPLCA_CLAIM_STATS_EN
    ,
    output logic [8:0]           free_count
`endif
);
    typedef enum logic [1:0] {OFF, WAIT_BEACON, TRACK} state_t;
    state_t state;
    logic [256*CLAIM_W-1:0] tbl_claim, tbl_aged;
    logic [255:0] seen, seen_m;
    logic [7:0] cnt;
    logic flag, in_txop, bcn_q, beacon_evt, bcn_raw, act, claim, roll;

    assign bcn_raw = (rx_cmd == 2'b00) || plca_tx_beacon;

    // The claim of a TXOP closing this clk is folded into seen/table before any rollover.
    always_comb begin
        act = CRS && !local_tx && (txop_start || in_txop || txop_end);
        claim = txop_end && (act || (flag && !txop_start));
        roll = beacon_evt && (cnt == 8'(AGING_CYCLES - 1));
        seen_m = seen;
        tbl_claim = txop_claim_table_unpacked;
        if (claim) begin
            seen_m[curID] = 1'b1;
            tbl_claim[{curID, 1'b0} +: 2] = 2'b10;
        end
        for (int i = 0; i < 256; i++)
            tbl_aged[2*i +: 2] = seen_m[i] ? 2'b10 :
                                 (txop_claim_table_unpacked[2*i +: 2] == 2'b10 ? 2'b01 : 2'b00);
    end

    always_ff @(posedge clk or negedge plca_reset_n) begin
        if (!plca_reset_n) begin
            state <= OFF;
            txop_claim_table_unpacked <= '0;
            seen <= '0;
            cnt <= '0;
            flag <= 1'b0;
            in_txop <= 1'b0;
            bcn_q <= 1'b0;
            beacon_evt <= 1'b0;
            dplca_txop_table_upd <= 1'b0;
            dplca_new_age <= 1'b0;
            dplca_txop_id <= '0;
            dplca_txop_node_count <= '0;
        end else begin
            bcn_q <= bcn_raw;
            beacon_evt <= bcn_raw && !bcn_q;
            dplca_txop_table_upd <= 1'b0;
            dplca_new_age <= 1'b0;
            if (state != OFF && !dplca_aging) begin
                state <= OFF;
            end else begin
                case (state)
                    OFF: begin
                        txop_claim_table_unpacked <= '0;
                        seen <= '0;
                        cnt <= '0;
                        flag <= 1'b0;
                        in_txop <= 1'b0;
                        dplca_txop_id <= '0;
                        dplca_txop_node_count <= '0;
                        if (dplca_aging && plca_status) state <= WAIT_BEACON;
                    end
                    WAIT_BEACON: begin
                        flag <= 1'b0;
                        in_txop <= 1'b0;
                        if (beacon_evt) begin
                            dplca_txop_node_count <= plca_node_count;
                            cnt <= '0;
                            state <= TRACK;
                        end
                    end
                    default: begin
                        if (!plca_status) begin
                            seen <= '0;
                            cnt <= '0;
                            flag <= 1'b0;
                            in_txop <= 1'b0;
                            state <= WAIT_BEACON;
                        end else begin
                            flag <= txop_start ? act : (flag || act);
                            in_txop <= (in_txop || txop_start) && !txop_end;
                            if (txop_end) begin
                                dplca_txop_id <= curID;
                                dplca_txop_table_upd <= 1'b1;
                            end
                            if (beacon_evt) begin
                                dplca_txop_node_count <= plca_node_count;
                                cnt <= roll ? 8'd0 : cnt + 8'd1;
                            end
                            if (roll) begin
                                txop_claim_table_unpacked <= tbl_aged;
                                seen <= '0;
                                dplca_txop_table_upd <= 1'b1;
                                dplca_new_age <= 1'b1;
                            end else begin
                                txop_claim_table_unpacked <= tbl_claim;
                                seen <= seen_m;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef DPLCA_CLAIM_STATS_EN
    logic [8:0] fc;
    always_comb begin
        fc = '0;
        for (int i = 0; i < 256; i++)
            fc = fc + 9'((txop_claim_table_unpacked[2*i +: 2] == 2'b01 ||
                          txop_claim_table_unpacked[2*i +: 2] == 2'b10) ? 0 : 1);
    end
    always_ff @(posedge clk or negedge plca_reset_n) begin
        if (!plca_reset_n) free_count <= 9'd256;
        else free_count <= fc;
    end
`endif
endmodule

// File: tb/tb_dplca_txop_claim_tracker.sv
// tb_dplca_txop_claim_tracker: scoreboard bench; stimulus pushes expected strobes, a negedge monitor pops and checks.
module tb_dplca_txop_claim_tracker;
    logic clk = 0, plca_reset_n = 0, dplca_aging = 0, plca_status = 0, plca_tx_beacon = 0;
    logic [1:0] rx_cmd = 2'b10;
    logic [7:0] plca_node_count = 8'd8, curID = 0;
    logic txop_start = 0, txop_end = 0, CRS = 0, local_tx = 0;
    logic [511:0] tbl;
    logic upd, new_age;
    logic [7:0] txop_id, node_cnt;
`ifdef DPLCA_CLAIM_STATS_EN
    logic [8:0] free_count;
`endif

    dplca_txop_claim_tracker #(.AGING_CYCLES(4)) dut (
        .clk(clk), .plca_reset_n(plca_reset_n), .dplca_aging(dplca_aging),
        .plca_status(plca_status), .rx_cmd(rx_cmd), .plca_tx_beacon(plca_tx_beacon),
        .plca_node_count(plca_node_count), .curID(curID), .txop_start(txop_start),
        .txop_end(txop_end), .CRS(CRS), .local_tx(local_tx),
        .txop_claim_table_unpacked(tbl), .dplca_txop_table_upd(upd),
        .dplca_new_age(new_age), .dplca_txop_id(txop_id),
        .dplca_txop_node_count(node_cnt)
`ifdef DPLCA_CLAIM_STATS_EN
        , .free_count(free_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic na;
        logic [7:0] id;
        int idx;
        logic [1:0] ent;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (plca_reset_n && (upd || new_age)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got upd=%0b new_age=%0b expected none", upd, new_age);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("upd", 32'(upd), 1);
                chk("new_age", 32'(new_age), 32'(e.na));
                chk("txop_id", 32'(txop_id), 32'(e.id));
                chk($sformatf("entry[%0d]", e.idx), 32'(tbl[2*e.idx +: 2]), 32'(e.ent));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beacon();
        rx_cmd = 2'b00;
        step();
        rx_cmd = 2'b10;
        step();
        step();
    endtask

    task automatic beacons(input int n);
        for (int i = 0; i < n; i++) beacon();
    endtask

    task automatic txop(input logic [7:0] id, input logic crs, input logic ltx);
        curID = id;
        CRS = crs;
        local_tx = ltx;
        txop_start = 1;
        step();
        txop_start = 0;
        step();
        txop_end = 1;
        step();
        txop_end = 0;
        CRS = 0;
        local_tx = 0;
        step();
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_tbl_nonzero"}, 32'(|tbl), 0);
        chk({nm, "_upd"}, 32'(upd), 0);
        chk({nm, "_new_age"}, 32'(new_age), 0);
        chk({nm, "_txop_id"}, 32'(txop_id), 0);
        chk({nm, "_node_count"}, 32'(node_cnt), 0);
`ifdef DPLCA_CLAIM_STATS_EN
        chk({nm, "_free_count"}, 32'(free_count), 256);
`endif
    endtask

    initial begin
        #12;
        all_zero("reset");
        plca_reset_n = 1;
        step();
        dplca_aging = 1;
        plca_status = 1;
        step();
        step();
        beacon();
        chk("node_count_latch", 32'(node_cnt), 8);
        // age 1: ID 3 claimed, ID 5 is local-only traffic
        q.push_back('{1'b0, 8'd3, 3, 2'b10});
        txop(8'd3, 1, 0);
`ifdef DPLCA_CLAIM_STATS_EN
        chk("free_count_one_hard", 32'(free_count), 255);
`endif
        q.push_back('{1'b0, 8'd5, 5, 2'b00});
        txop(8'd5, 1, 1);
        beacons(3);
        q.push_back('{1'b1, 8'd5, 3, 2'b10});
        beacon();
        beacons(3);
        q.push_back('{1'b1, 8'd5, 3, 2'b01});
        beacon();
        beacons(3);
        q.push_back('{1'b1, 8'd5, 3, 2'b00});
        beacon();
        beacons(3);
        // txop_end on the rollover clk
        plca_node_count = 8'd9;
        q.push_back('{1'b1, 8'd7, 7, 2'b10});
        curID = 8'd7;
        CRS = 1;
        txop_start = 1;
        step();
        txop_start = 0;
        step();
        rx_cmd = 2'b00;
        step();
        rx_cmd = 2'b10;
        txop_end = 1;
        step();
        txop_end = 0;
        CRS = 0;
        step();
        step();
        chk("node_count_relatch", 32'(node_cnt), 9);
        // status FAIL: table held, no strobes; counter restarts after OK + beacon
        beacon();
        q.push_back('{1'b0, 8'd2, 2, 2'b10});
        txop(8'd2, 1, 0);
        plca_status = 0;
        step();
        step();
        txop(8'd4, 1, 0);
        chk("fail_hold_entry2", 32'(tbl[5:4]), 2);
        chk("fail_no_claim4", 32'(tbl[9:8]), 0);
        chk("fail_txop_id", 32'(txop_id), 2);
        plca_status = 1;
        step();
        beacon();
        beacons(3);
        q.push_back('{1'b1, 8'd2, 2, 2'b01});
        beacon();
        chk("aged_entry7", 32'(tbl[15:14]), 1);
        // aging dropped mid-TXOP
        curID = 8'd9;
        CRS = 1;
        txop_start = 1;
        step();
        txop_start = 0;
        dplca_aging = 0;
        step();
        step();
        step();
        CRS = 0;
        all_zero("aging_off");
        // reset mid-TXOP
        dplca_aging = 1;
        step();
        step();
        beacon();
        q.push_back('{1'b0, 8'd1, 1, 2'b10});
        txop(8'd1, 1, 0);
        curID = 8'd6;
        CRS = 1;
        txop_start = 1;
        step();
        txop_start = 0;
        #2;
        plca_reset_n = 0;
        #1;
        all_zero("async_reset");
        CRS = 0;
        step();
        step();
        chk("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
